truth_table_sequencer: RTL and testbench

- Upstream stimulus and checking stage for the small combinational gate modules in the guides.
- Each such module has a behavioural form and a gate-level form; this block drives both with a shared input vector.
- It walks every input combination, waits for a settle window, compares the two outputs, and reports the first mismatch, the mismatch count, and pass/fail.
- It replaces the hand-written #1 stimulus list with a clocked, self-checking sequencer.

---
 rtl/tt_seq_pkg.sv | 23 ++
 rtl/tt_settle_timer.sv | 30 +++
 rtl/truth_table_sequencer.sv | 161 ++++++++++++++++
 tb/tb_truth_table_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_seq_pkg.sv
// Shared definitions for the truth-table sequencer: FSM state encoding,
// default sizing constants and the settle-timer width helper.
package tt_seq_pkg;

  localparam int N_IN_DEF   = 2;
  localparam int SETTLE_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Settle counter must hold SETTLE itself; never narrower than one bit.
  function automatic int timer_width(input int settle);
    int w;
    w = $clog2(settle + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that flags the last cycle of a settle window
// (count == 1) so the sequencer can move on to sampling.
module tt_settle_timer
  import tt_seq_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expire = (count == W'(1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Clocked stimulus/compare sequencer: sweeps every input vector, compares a
// behavioural and a gate-level output, and reports mismatch statistics.
// Optional truth-table bitmap output enabled by defining TT_RESP_MAP_EN.
module truth_table_sequencer
  import tt_seq_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            ref_in,
  input  logic            dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_err_valid,
  output logic [N_IN-1:0] first_err_vec,
  output state_t          state
`ifdef TT_RESP_MAP_EN
  ,
  output logic [(1<<N_IN)-1:0] resp_map
`endif
);

  localparam int              TW   = timer_width(SETTLE);
  localparam logic [TW-1:0]   LOAD = TW'(SETTLE);
  localparam logic [N_IN-1:0] LAST = '1;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [N_IN:0]     err_q, err_d;
  logic [N_IN:0]     err_inc;
  logic              fev_q, fev_d;
  logic [N_IN-1:0]   fevec_q, fevec_d;
  logic              mism;
  logic              tmr_load, tmr_dec, tmr_expire;
`ifdef TT_RESP_MAP_EN
  logic [(1<<N_IN)-1:0] resp_q, resp_d;
`endif

  tt_settle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (LOAD),
    .dec      (tmr_dec),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fev_d    = fev_q;
    fevec_d  = fevec_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    mism     = ref_in ^ dut_in;
    err_inc  = err_q + {{N_IN{1'b0}}, mism};
`ifdef TT_RESP_MAP_EN
    resp_d   = resp_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          err_d   = '0;
          fev_d   = 1'b0;
          fevec_d = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          vec_d   = '0;
          busy_d  = 1'b1;
`ifdef TT_RESP_MAP_EN
          resp_d  = '0;
`endif
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        tmr_load = 1'b1;
        state_d  = (SETTLE > 0) ? ST_WAIT : ST_SAMPLE;
      end
      ST_WAIT: begin
        tmr_dec = 1'b1;
        if (tmr_expire) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        err_d = err_inc;
        if (mism && !fev_q) begin
          fev_d   = 1'b1;
          fevec_d = vec_q;
        end
`ifdef TT_RESP_MAP_EN
        resp_d[vec_q] = dut_in;
`endif
        // Last vector is held on vec_out; pass uses the count including it.
        if (vec_q == LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_inc == '0);
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + N_IN'(1);
          state_d = ST_APPLY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fevec_q <= '0;
`ifdef TT_RESP_MAP_EN
      resp_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fevec_q <= fevec_d;
`ifdef TT_RESP_MAP_EN
      resp_q  <= resp_d;
`endif
    end
  end

  assign state           = state_q;
  assign vec_out         = vec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_vec   = fevec_q;
`ifdef TT_RESP_MAP_EN
  assign resp_map        = resp_q;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: two instances (SETTLE=1 and SETTLE=0) driven
// from truth tables, checked against a sweep-level reference model.
module tb_truth_table_sequencer;
  import tt_seq_pkg::*;

  localparam int N  = 2;
  localparam int NV = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0;
  logic start_z = 1'b0;
  logic sel_z = 1'b0;

  logic [NV-1:0] ref_tbl;
  logic [NV-1:0] dut_tbl;

  logic [N-1:0] vec_a, vec_z, fevec_a, fevec_z;
  logic [N:0]   err_a, err_z;
  logic         busy_a, busy_z, done_a, done_z, pass_a, pass_z, fev_a, fev_z;
  logic         ref_a, ref_z, gate_a, gate_z;
  state_t       st_a, st_z;
`ifdef TT_RESP_MAP_EN
  logic [NV-1:0] resp_a, resp_z;
`endif

  // Observation mux so one set of tasks can check either instance.
  logic [N-1:0] o_vec, o_fevec;
  logic [N:0]   o_err;
  logic         o_busy, o_done, o_pass, o_fev;
  state_t       o_state;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  always #5 clk = ~clk;

  assign ref_a  = ref_tbl[vec_a];
  assign gate_a = dut_tbl[vec_a];
  assign ref_z  = ref_tbl[vec_z];
  assign gate_z = dut_tbl[vec_z];

  assign o_vec   = sel_z ? vec_z   : vec_a;
  assign o_fevec = sel_z ? fevec_z : fevec_a;
  assign o_err   = sel_z ? err_z   : err_a;
  assign o_busy  = sel_z ? busy_z  : busy_a;
  assign o_done  = sel_z ? done_z  : done_a;
  assign o_pass  = sel_z ? pass_z  : pass_a;
  assign o_fev   = sel_z ? fev_z   : fev_a;
  assign o_state = sel_z ? st_z    : st_a;

  truth_table_sequencer #(.N_IN(N), .SETTLE(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .vec_out(vec_a),
    .ref_in(ref_a), .dut_in(gate_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .first_err_valid(fev_a),
    .first_err_vec(fevec_a), .state(st_a)
`ifdef TT_RESP_MAP_EN
    , .resp_map(resp_a)
`endif
  );

  truth_table_sequencer #(.N_IN(N), .SETTLE(0)) u_z (
    .clk(clk), .rst(rst), .start(start_z), .vec_out(vec_z),
    .ref_in(ref_z), .dut_in(gate_z), .busy(busy_z), .done(done_z),
    .pass(pass_z), .err_count(err_z), .first_err_valid(fev_z),
    .first_err_vec(fevec_z), .state(st_z)
`ifdef TT_RESP_MAP_EN
    , .resp_map(resp_z)
`endif
  );

  // Behavioural form f(x,y) = x | ~y, x = MSB of the vector.
  task automatic build_ref();
    int x, y;
    for (int v = 0; v < NV; v++) begin
      x = (v / 2) % 2;
      y = v % 2;
      ref_tbl[v] = (x == 1) || (y == 0);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({o_vec, o_busy, o_done, o_pass, o_err, o_fev, o_fevec} !== '0 || o_state !== ST_IDLE) begin
      errors++;
      $display("FAIL %s outputs vec=%0d busy=%0b done=%0b pass=%0b err=%0d fev=%0b fevec=%0d state=%0d required all 0",
               name, o_vec, o_busy, o_done, o_pass, o_err, o_fev, o_fevec, o_state);
    end
  endtask

  // Full sweep on one instance; optional extra start pulse at glitch_edge.
  task automatic do_sweep(input string name, input bit z, input int glitch_edge);
    int per, total, exp_err, exp_first, got;
    bit exp_fev;
    logic [N-1:0] exp_v;
    sel_z = z;
    per = z ? 2 : 3;
    total = NV * per;
    exp_err = 0; exp_fev = 0; exp_first = 0;
    for (int v = 0; v < NV; v++) begin
      if (ref_tbl[v] != dut_tbl[v]) begin
        if (!exp_fev) exp_first = v;
        exp_fev = 1;
        exp_err++;
      end
    end
    exp_q.delete();
    for (int v = 0; v < NV; v++)
      for (int r = 0; r < per; r++) exp_q.push_back(N'(v));
    exp_q.push_back(N'(NV - 1));

    @(negedge clk);
    if (z) start_z = 1'b1; else start_a = 1'b1;
    got = -1;
    for (int k = 0; k <= total + 20 && got < 0; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (z) start_z = (k == glitch_edge); else start_a = (k == glitch_edge);
      end
      @(posedge clk);
      #1;
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : N'(NV - 1);
      checks++;
      if (o_vec !== exp_v) begin
        errors++;
        $display("FAIL %s vec_out edge %0d got %0d required %0d", name, k, o_vec, exp_v);
      end
      checks++;
      if (o_busy !== (k < total)) begin
        errors++;
        $display("FAIL %s busy edge %0d got %0b required %0b", name, k, o_busy, (k < total));
      end
      if (o_done === 1'b1) got = k;
    end
    start_a = 1'b0;
    start_z = 1'b0;
    checks++;
    if (got != total) begin
      errors++;
      $display("FAIL %s done_edge got %0d required %0d", name, got, total);
    end
    checks++;
    if (o_err !== (N+1)'(exp_err)) begin
      errors++;
      $display("FAIL %s err_count got %0d required %0d", name, o_err, exp_err);
    end
    checks++;
    if (o_fev !== exp_fev || o_fevec !== N'(exp_first)) begin
      errors++;
      $display("FAIL %s first_err got %0b/%0d required %0b/%0d", name, o_fev, o_fevec, exp_fev, exp_first);
    end
    checks++;
    if (o_pass !== (exp_err == 0)) begin
      errors++;
      $display("FAIL %s pass got %0b required %0b", name, o_pass, (exp_err == 0));
    end
`ifdef TT_RESP_MAP_EN
    checks++;
    if ((z ? resp_z : resp_a) !== dut_tbl) begin
      errors++;
      $display("FAIL %s resp_map got %b required %b", name, (z ? resp_z : resp_a), dut_tbl);
    end
`endif
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    sel_z = 1'b0;
    #0 check_all_zero("reset_a");
    sel_z = 1'b1;
    #1 check_all_zero("reset_z");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_matched();
    dut_tbl = ref_tbl;
    do_sweep("matched", 1'b0, -1);
`ifdef TT_RESP_MAP_EN
    checks++;
    if (resp_a !== 4'b1101) begin
      errors++;
      $display("FAIL resp_map_const got %b required 1101", resp_a);
    end
`endif
  endtask

  task automatic test_stuck0();
    dut_tbl = '0;
    do_sweep("stuck0", 1'b0, -1);
  endtask

  task automatic test_settle0();
    dut_tbl = ref_tbl;
    do_sweep("settle0_matched", 1'b1, -1);
    dut_tbl = '0;
    do_sweep("settle0_stuck0", 1'b1, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      dut_tbl = NV'($urandom_range(0, NV == 4 ? 15 : 0));
      do_sweep($sformatf("random%0d", i), (i % 2) == 1, -1);
    end
  endtask

  task automatic test_mid_reset();
    sel_z = 1'b0;
    dut_tbl = '0;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (err_a !== 3'd1) begin
      errors++;
      $display("FAIL mid_reset pre err_count got %0d required 1", err_a);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    dut_tbl = ref_tbl;
    do_sweep("after_reset", 1'b0, -1);
  endtask

  task automatic test_ignored_start();
    dut_tbl = ref_tbl;
    do_sweep("ignored_start", 1'b0, 3);
  endtask

  task automatic test_restart();
    int got;
    dut_tbl = '0;
    do_sweep("restart_pre", 1'b0, -1);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b1 || done_a !== 1'b0 || err_a !== '0 || fev_a !== 1'b0 || pass_a !== 1'b0) begin
      errors++;
      $display("FAIL restart busy/done/err/fev/pass got %0b/%0b/%0d/%0b/%0b required 1/0/0/0/0",
               busy_a, done_a, err_a, fev_a, pass_a);
    end
    @(negedge clk);
    start_a = 1'b0;
    got = -1;
    for (int k = 1; k <= 40 && got < 0; k++) begin
      if (k > 1) @(negedge clk);
      @(posedge clk);
      #1;
      if (done_a === 1'b1) got = k;
    end
    checks++;
    if (got != 12 || err_a !== 3'd3) begin
      errors++;
      $display("FAIL restart_sweep done_edge/err got %0d/%0d required 12/3", got, err_a);
    end
  endtask

  initial begin
    build_ref();
    dut_tbl = ref_tbl;
    test_reset();
    test_matched();
    test_stuck0();
    test_settle0();
    test_random();
    test_mid_reset();
    test_ignored_start();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
